// File: rtl/change_dispenser.sv
// Purpose : vending-machine change dispenser; dispenses the selected item, then pays change greedily in 20/10/5 coins.
// Latency : transaction starts the cycle after an end_trans rise in IDLE; each item/coin request holds until acknowledged.
// Backpr. : item_req/coin_req are held until item_ack/coin_ack; new end_trans rises are ignored while busy.
//
// Ports:
//   clk, reset_n (async, active-low)
//   end_trans, sum_money[7:0], price[7:0], item_select[1:0]  transaction request from the vending controller
//   restock                                                 reload stock counters (IDLE only)
//   item_req/item_id[1:0]/item_ack                          dispenser motor handshake
//   coin_req/coin_sel[1:0]/coin_ack                         coin hopper handshake (01=5, 10=10, 11=20)
//   done, refunded, short_change[2:0]                       completion pulse and its result
//   busy, stock_empty[3:0]                                  status decoded from registers
//
// Optional feature: define DISPENSE_TIMEOUT_EN to abandon DISPENSE after TIMEOUT_CYC cycles without
// item_ack; the item is then treated as unavailable and the full sum is refunded.

module change_dispenser #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       end_trans,
    input  logic [7:0] sum_money,
    input  logic [7:0] price,
    input  logic [1:0] item_select,
    input  logic       restock,
    input  logic       item_ack,
    input  logic       coin_ack,
    output logic       item_req,
    output logic [1:0] item_id,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic       done,
    output logic       refunded,
    output logic [2:0] short_change,
    output logic       busy,
    output logic [3:0] stock_empty
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        DISPENSE  = 3'd2,
        CHANGE    = 3'd3,
        WAIT_COIN = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Initial stock after reset or restock, items 0..3.
    localparam logic [2:0] STOCK0 = 3'd7;
    localparam logic [2:0] STOCK1 = 3'd5;
    localparam logic [2:0] STOCK2 = 3'd3;
    localparam logic [2:0] STOCK3 = 3'd0;

    state_t     state_q, state_d;
    logic       end_trans_prev_q, end_trans_prev_d;   // end_trans delayed one cycle, for edge detect
    logic [7:0] sum_q, sum_d;
    logic [7:0] price_q, price_d;
    logic [1:0] item_q, item_d;
    logic [7:0] change_q, change_d;
    logic       refund_q, refund_d;
    logic [2:0] stock_q [4];
    logic [2:0] stock_d [4];

    logic       item_req_q, item_req_d;
    logic [1:0] item_id_q, item_id_d;
    logic       coin_req_q, coin_req_d;
    logic [1:0] coin_sel_q, coin_sel_d;
    logic       done_q, done_d;
    logic       refunded_q, refunded_d;
    logic [2:0] short_change_q, short_change_d;

    logic [7:0] coin_val;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Value of the coin currently being ejected.
    always_comb begin
        coin_val = 8'd0;
        case (coin_sel_q)
            2'b01:   coin_val = 8'd5;
            2'b10:   coin_val = 8'd10;
            2'b11:   coin_val = 8'd20;
            default: coin_val = 8'd0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        end_trans_prev_d = end_trans;
        sum_d            = sum_q;
        price_d          = price_q;
        item_d           = item_q;
        change_d         = change_q;
        refund_d         = refund_q;
        stock_d          = stock_q;
        item_req_d       = item_req_q;
        item_id_d        = item_id_q;
        coin_req_d       = coin_req_q;
        coin_sel_d       = coin_sel_q;
        done_d           = 1'b0;
        refunded_d       = refunded_q;
        short_change_d   = short_change_q;
`ifdef DISPENSE_TIMEOUT_EN
        tmo_d            = '0;
`endif

        case (state_q)
            IDLE: begin
                if (restock) begin
                    stock_d[0] = STOCK0;
                    stock_d[1] = STOCK1;
                    stock_d[2] = STOCK2;
                    stock_d[3] = STOCK3;
                end
                if (end_trans && !end_trans_prev_q) begin
                    sum_d   = sum_money;
                    price_d = price;
                    item_d  = item_select;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                // Out of stock or underpaid: refund everything. This also keeps stock from underflowing.
                if (stock_q[item_q] == 3'd0 || sum_q < price_q) begin
                    change_d = sum_q;
                    refund_d = 1'b1;
                    state_d  = CHANGE;
                end else begin
                    change_d   = sum_q - price_q;
                    refund_d   = 1'b0;
                    item_req_d = 1'b1;
                    item_id_d  = item_q;
                    state_d    = DISPENSE;
                end
            end

            DISPENSE: begin
                if (item_ack) begin
                    stock_d[item_q] = stock_q[item_q] - 3'd1;
                    item_req_d      = 1'b0;
                    item_id_d       = 2'd0;
                    state_d         = CHANGE;
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    // Motor never answered: the item was not delivered, so refund in full.
                    item_req_d = 1'b0;
                    item_id_d  = 2'd0;
                    change_d   = sum_q;
                    refund_d   = 1'b1;
                    state_d    = CHANGE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end

            CHANGE: begin
                if (change_q >= 8'd20) begin
                    coin_req_d = 1'b1;
                    coin_sel_d = 2'b11;
                    state_d    = WAIT_COIN;
                end else if (change_q >= 8'd10) begin
                    coin_req_d = 1'b1;
                    coin_sel_d = 2'b10;
                    state_d    = WAIT_COIN;
                end else if (change_q >= 8'd5) begin
                    coin_req_d = 1'b1;
                    coin_sel_d = 2'b01;
                    state_d    = WAIT_COIN;
                end else begin
                    done_d         = 1'b1;
                    short_change_d = change_q[2:0];
                    refunded_d     = refund_q;
                    state_d        = DONE;
                end
            end

            WAIT_COIN: begin
                if (coin_ack) begin
                    change_d   = change_q - coin_val;
                    coin_req_d = 1'b0;
                    coin_sel_d = 2'b00;
                    state_d    = CHANGE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            end_trans_prev_q <= 1'b0;
            sum_q            <= 8'd0;
            price_q          <= 8'd0;
            item_q           <= 2'd0;
            change_q         <= 8'd0;
            refund_q         <= 1'b0;
            stock_q[0]       <= STOCK0;
            stock_q[1]       <= STOCK1;
            stock_q[2]       <= STOCK2;
            stock_q[3]       <= STOCK3;
            item_req_q       <= 1'b0;
            item_id_q        <= 2'd0;
            coin_req_q       <= 1'b0;
            coin_sel_q       <= 2'd0;
            done_q           <= 1'b0;
            refunded_q       <= 1'b0;
            short_change_q   <= 3'd0;
`ifdef DISPENSE_TIMEOUT_EN
            tmo_q            <= '0;
`endif
        end else begin
            state_q          <= state_d;
            end_trans_prev_q <= end_trans_prev_d;
            sum_q            <= sum_d;
            price_q          <= price_d;
            item_q           <= item_d;
            change_q         <= change_d;
            refund_q         <= refund_d;
            stock_q          <= stock_d;
            item_req_q       <= item_req_d;
            item_id_q        <= item_id_d;
            coin_req_q       <= coin_req_d;
            coin_sel_q       <= coin_sel_d;
            done_q           <= done_d;
            refunded_q       <= refunded_d;
            short_change_q   <= short_change_d;
`ifdef DISPENSE_TIMEOUT_EN
            tmo_q            <= tmo_d;
`endif
        end
    end

    assign item_req     = item_req_q;
    assign item_id      = item_id_q;
    assign coin_req     = coin_req_q;
    assign coin_sel     = coin_sel_q;
    assign done         = done_q;
    assign refunded     = refunded_q;
    assign short_change = short_change_q;
    assign busy         = (state_q != IDLE);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stock_empty[i] = (stock_q[i] == 3'd0);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       end_trans = 1'b0;
    logic [7:0] sum_money = 8'd0;
    logic [7:0] price = 8'd0;
    logic [1:0] item_select = 2'd0;
    logic       restock = 1'b0;
    logic       item_ack = 1'b0;
    logic       coin_ack = 1'b0;
    logic       item_req;
    logic [1:0] item_id;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       done;
    logic       refunded;
    logic [2:0] short_change;
    logic       busy;
    logic [3:0] stock_empty;

    change_dispenser #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .end_trans    (end_trans),
        .sum_money    (sum_money),
        .price        (price),
        .item_select  (item_select),
        .restock      (restock),
        .item_ack     (item_ack),
        .coin_ack     (coin_ack),
        .item_req     (item_req),
        .item_id      (item_id),
        .coin_req     (coin_req),
        .coin_sel     (coin_sel),
        .done         (done),
        .refunded     (refunded),
        .short_change (short_change),
        .busy         (busy),
        .stock_empty  (stock_empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int item_dly = 2;     // 0 = never acknowledge
    int coin_dly = 2;     // 0 = never acknowledge
    int req_hi = 0;       // cycles item_req stayed high in the latest request
    logic prev_item = 1'b0;
    logic prev_coin = 1'b0;

    // Event encoding: type in [7:6] (1=item, 2=coin, 3=done), payload below.
    function automatic logic [7:0] ev_item(input logic [1:0] id);
        return {2'd1, 4'd0, id};
    endfunction
    function automatic logic [7:0] ev_coin(input logic [1:0] sel);
        return {2'd2, 4'd0, sel};
    endfunction
    function automatic logic [7:0] ev_done(input logic rf, input logic [2:0] sc);
        return {2'd3, 2'd0, rf, sc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic see_ev(input string name, input logic [7:0] ev);
        logic [7:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got event %0h, expected no event", name, ev);
        end else begin
            e = exp_q.pop_front();
            if (e !== ev) begin
                n_err++;
                $display("FAIL %s: got event %0h, expected %0h", name, ev, e);
            end
        end
    endtask

    // Monitor: every output event is checked against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_item = 1'b0;
                prev_coin = 1'b0;
            end else begin
                if (item_req && !prev_item) begin
                    see_ev("item_req", ev_item(item_id));
                    req_hi = 0;
                end
                if (item_req) req_hi++;
                if (coin_req && !prev_coin) see_ev("coin_req", ev_coin(coin_sel));
                if (done) see_ev("done", ev_done(refunded, short_change));
                prev_item = item_req;
                prev_coin = coin_req;
            end
        end
    end

    // Dispenser motor model.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (item_req && reset_n) begin
                cnt++;
                item_ack = (cnt == item_dly);
            end else begin
                cnt = 0;
                item_ack = 1'b0;
            end
        end
    end

    // Coin hopper model.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (coin_req && reset_n) begin
                cnt++;
                coin_ack = (cnt == coin_dly);
            end else begin
                cnt = 0;
                coin_ack = 1'b0;
            end
        end
    end

    task automatic run_txn(input logic [7:0] s, input logic [7:0] p, input logic [1:0] it);
        @(negedge clk);
        sum_money   = s;
        price       = p;
        item_select = it;
        end_trans   = 1'b1;
        @(negedge clk);
        end_trans   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_timeout: done not seen, expected within 400 cycles", name);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_item_req", item_req, 0);
        check("rst_coin_req", coin_req, 0);
        check("rst_done", done, 0);
        check("rst_coin_sel", coin_sel, 0);
        check("rst_short", short_change, 0);
        check("rst_stock_empty", stock_empty, 4'b1000);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // 31 - 15 = 16 -> 10 + 5, residue 1
        exp_q.push_back(ev_item(2'd0));
        exp_q.push_back(ev_coin(2'b10));
        exp_q.push_back(ev_coin(2'b01));
        exp_q.push_back(ev_done(1'b0, 3'd1));
        run_txn(8'd31, 8'd15, 2'd0);
        wait_done("t1");
        check("t1_stock0", dut.stock_q[0], 6);

        // Item 3 out of stock: refund 22 -> 20, residue 2
        exp_q.push_back(ev_coin(2'b11));
        exp_q.push_back(ev_done(1'b1, 3'd2));
        run_txn(8'd22, 8'd10, 2'd3);
        wait_done("t2");

        // Underpaid: refund 15 -> 10 + 5
        exp_q.push_back(ev_coin(2'b10));
        exp_q.push_back(ev_coin(2'b01));
        exp_q.push_back(ev_done(1'b1, 3'd0));
        run_txn(8'd15, 8'd31, 2'd1);
        wait_done("t3");
        check("t3_stock1", dut.stock_q[1], 5);

        // Greedy: 45 -> 20 + 20 + 5
        exp_q.push_back(ev_item(2'd0));
        exp_q.push_back(ev_coin(2'b11));
        exp_q.push_back(ev_coin(2'b11));
        exp_q.push_back(ev_coin(2'b01));
        exp_q.push_back(ev_done(1'b0, 3'd0));
        run_txn(8'd45, 8'd0, 2'd0);
        wait_done("t4");
        check("t4_stock0", dut.stock_q[0], 5);

        // end_trans held 5 cycles, then a second rise while busy: one transaction only
        item_dly = 6;
        exp_q.push_back(ev_item(2'd2));
        exp_q.push_back(ev_done(1'b0, 3'd0));
        @(negedge clk);
        sum_money = 8'd10; price = 8'd10; item_select = 2'd2;
        end_trans = 1'b1;
        repeat (5) @(negedge clk);
        end_trans = 1'b0;
        @(negedge clk);
        end_trans = 1'b1;
        check("t5_busy_at_rise", busy, 1);
        @(negedge clk);
        end_trans = 1'b0;
        wait_done("t5");
        repeat (10) @(negedge clk);
        item_dly = 2;
        check("t5_queue_empty", exp_q.size(), 0);

        // Drain item 2 (stock now 2)
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(ev_item(2'd2));
            exp_q.push_back(ev_done(1'b0, 3'd0));
            run_txn(8'd8, 8'd8, 2'd2);
            wait_done("t6_buy");
        end
        check("t6_stock_empty", stock_empty, 4'b1100);

        // Empty item 2 refunds; restock pulsed while busy is ignored
        exp_q.push_back(ev_coin(2'b01));
        exp_q.push_back(ev_done(1'b1, 3'd3));
        run_txn(8'd8, 8'd8, 2'd2);
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        wait_done("t7");
        check("t7_restock_busy", stock_empty, 4'b1100);

        // Restock in IDLE
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        @(negedge clk);
        check("t8_restock_idle", stock_empty, 4'b1000);
        check("t8_stock0", dut.stock_q[0], 7);

`ifdef DISPENSE_TIMEOUT_EN
        // No item_ack: item_req high 16 cycles, full refund 25 -> 20 + 5, stock unchanged
        item_dly = 0;
        exp_q.push_back(ev_item(2'd0));
        exp_q.push_back(ev_coin(2'b11));
        exp_q.push_back(ev_coin(2'b01));
        exp_q.push_back(ev_done(1'b1, 3'd0));
        run_txn(8'd25, 8'd10, 2'd0);
        wait_done("t9");
        check("t9_req_cycles", req_hi, 16);
        check("t9_stock0", dut.stock_q[0], 7);
        item_dly = 2;
`endif

        // Reset during WAIT_COIN
        coin_dly = 0;
        exp_q.push_back(ev_item(2'd1));
        exp_q.push_back(ev_coin(2'b11));
        run_txn(8'd30, 8'd5, 2'd1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (coin_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t10_coin_req_seen", seen, 1);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t10_coin_req_rst", coin_req, 0);
        check("t10_busy_rst", busy, 0);
        check("t10_coin_sel_rst", coin_sel, 0);
        @(negedge clk);
        reset_n = 1'b1;
        coin_dly = 2;
        repeat (3) @(negedge clk);
        check("t10_stock_empty", stock_empty, 4'b1000);
        check("t10_stock1", dut.stock_q[1], 5);
        check("t10_idle", busy, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, default 16, item_ack wait limit in cycles (used only with DISPENSE_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: end_trans  input  1  transaction-complete level from the vending controller.
REQ-005 SHALL have port: sum_money  input  8  money inserted; valid while end_trans=1.
REQ-006 SHALL have port: price  input  8  item price; valid while end_trans=1.
REQ-007 SHALL have port: item_select  input  2  item index 0..3; valid while end_trans=1.
REQ-008 SHALL have port: restock  input  1  reload stock counters; honoured only in IDLE.
REQ-009 SHALL have port: item_ack  input  1  dispenser motor acknowledge.
REQ-010 SHALL have port: coin_ack  input  1  coin hopper acknowledge.
REQ-011 SHALL have port: item_req  output  1  item dispense request.
REQ-012 SHALL have port: item_id  output  2  item to dispense; valid while item_req=1.
REQ-013 SHALL have port: coin_req  output  1  coin eject request.
REQ-014 SHALL have port: coin_sel  output  2  coin to eject: 01=5, 10=10, 11=20; 00 when coin_req=0.
REQ-015 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port: refunded  output  1  full refund flag; valid with done.
REQ-017 SHALL have port: short_change  output  3  unpayable residue (<5); valid with done.
REQ-018 SHALL have port: busy  output  1  high when state != IDLE.
REQ-019 SHALL have port: stock_empty  output  4  bit i high when stock[i]=0.

Function
REQ-020 SHALL implement FSM states IDLE, CHECK, DISPENSE, CHANGE, WAIT_COIN, DONE.
REQ-021 SHALL start a transaction only in IDLE, on end_trans=1 with registered end_trans_d=0, capturing sum_money, price and item_select, then going to CHECK.
REQ-022 SHALL ignore end_trans rising edges in any state other than IDLE, while end_trans_d is still updated every cycle.
REQ-023 SHALL, in CHECK, go to CHANGE with change=sum and refund=1 when stock[item]=0 or sum<price; otherwise go to DISPENSE with change=sum-price (8-bit, no wrap) and refund=0.
REQ-024 SHALL, in DISPENSE, hold item_req=1 and item_id=item until item_ack=1 is sampled, then decrement stock[item] and go to CHANGE.
REQ-025 SHALL ignore item_ack and coin_ack while the corresponding request is low.
REQ-026 SHALL, in CHANGE, choose coins greedily (20 if change>=20, else 10 if change>=10, else 5 if change>=5), go to WAIT_COIN, and go to DONE when change<5.
REQ-027 SHALL, in WAIT_COIN, hold coin_req=1 and coin_sel until coin_ack=1, then subtract the coin value and return to CHANGE.
REQ-028 SHALL, in DONE, pulse done=1 for one cycle with short_change=change[2:0] and refunded=refund, then return to IDLE.
REQ-029 SHALL, on restock=1 in IDLE, load stock counters to 7,5,3,0 for items 0..3, and SHALL ignore restock in all other states.
REQ-030 SHALL use 3-bit stock counters that never decrement below 0, which is guaranteed by CHECK.
REQ-031 SHALL register all outputs except busy and stock_empty, which are decoded from registers.

Reset
REQ-032 SHALL, while reset_n=0, immediately set state=IDLE; item_req, coin_req, done, refunded and busy to 0; coin_sel, item_id and short_change to 0; end_trans_d=0; and stock to 7,5,3,0, giving stock_empty=4'b1000.
REQ-033 SHALL abandon any transaction interrupted by reset with no resumption, and SHALL drop requests in the same cycle that reset asserts.

Configuration
REQ-034 SHALL, when macro DISPENSE_TIMEOUT_EN is defined, count cycles in DISPENSE and, when TIMEOUT_CYC cycles pass without item_ack, drop item_req, leave stock unchanged, set change=sum and refund=1, and go to CHANGE.
REQ-035 SHALL, when DISPENSE_TIMEOUT_EN is undefined, wait in DISPENSE indefinitely and contain no timeout counter.

Verification
REQ-036 SHALL cover: sum=31, price=15, item=0, acks after 2 cycles -> item_req id 0, coins 10 then 5, done with short_change=1, refunded=0, stock[0]=6.
REQ-037 SHALL cover: item=3 (stock 0), sum=22 -> no item_req, coin 20, done with short_change=2, refunded=1.
REQ-038 SHALL cover: sum=15, price=31, item=1 -> no item_req, coins 10 then 5, short_change=0, refunded=1, stock[1]=5.
REQ-039 SHALL cover: end_trans held high 5 cycles plus a second rise while busy -> exactly one transaction and one done.
REQ-040 SHALL cover: reset_n low during WAIT_COIN -> coin_req=0 immediately, busy=0, stock_empty=4'b1000 after release.
REQ-041 SHALL cover, with DISPENSE_TIMEOUT_EN: item_ack never asserted -> item_req drops after 16 cycles, full refund coins, refunded=1, stock unchanged.
